// File: rtl/gpio_hex_display.sv
// Converts the core's 32-bit GPIO output into eight active-low seven-segment digits.
// Decimal mode runs a serial double-dabble (one bit per cycle); hex mode shows raw nibbles.
module gpio_hex_display #(
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] gpio_value,
    input  logic        hex_mode,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned VAL_W  = 32;
    localparam int unsigned BCD_W  = 40;
    localparam int unsigned BCD_N  = 10;
    localparam int unsigned CNT_W  = 6;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned SEG_W  = 7;

    localparam logic [SEG_W-1:0] SEG_ZERO  = 7'h40;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
    localparam logic [SEG_W-1:0] RST_HI    = BLANK_LEADING ? SEG_BLANK : SEG_ZERO;
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(VAL_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_e;

    state_e                         state_q, state_d;
    logic [VAL_W-1:0]               src_q, src_d;
    logic                           disp_hex_q, disp_hex_d;
    logic [VAL_W-1:0]               shreg_q, shreg_d;
    logic [BCD_W-1:0]               bcd_q, bcd_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [DIGITS-1:0][SEG_W-1:0]   seg_q, seg_d;
    logic                           busy_q, busy_d;
    logic                           ovf_q, ovf_d;

    logic [BCD_W-1:0]               bcd_adj;
    logic [DIGITS-1:0][3:0]         new_dig;
    logic [DIGITS-1:0]              blank;
    logic                           disp_upd;
    logic                           higher_zero;

    function automatic logic [SEG_W-1:0] seg7(input logic [3:0] d);
        logic [SEG_W-1:0] s;
        case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Next-state, datapath and display update
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        disp_hex_d  = disp_hex_q;
        shreg_d     = shreg_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        seg_d       = seg_q;
        ovf_d       = ovf_q;
        bcd_adj     = bcd_q;
        new_dig     = '0;
        blank       = '0;
        disp_upd    = 1'b0;
        higher_zero = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (hex_mode) begin
                    src_d      = gpio_value;
                    disp_hex_d = 1'b1;
                    ovf_d      = 1'b0;
                    new_dig    = gpio_value;
                    disp_upd   = 1'b1;
                end else if ((gpio_value != src_q) || disp_hex_q) begin
                    src_d   = gpio_value;
                    shreg_d = gpio_value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                for (int i = 0; i < BCD_N; i++) begin
                    if (bcd_q[4*i +: 4] >= 4'd5) begin
                        bcd_adj[4*i +: 4] = 4'(bcd_q[4*i +: 4] + 4'd3);
                    end
                end
                {bcd_d, shreg_d} = (BCD_W + VAL_W)'({bcd_adj, shreg_q} << 1);
                cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A result is dropped if the user flipped to hex mid-conversion
                if (!hex_mode) begin
                    new_dig    = bcd_q[VAL_W-1:0];
                    ovf_d      = |bcd_q[BCD_W-1:VAL_W];
                    disp_hex_d = 1'b0;
                    disp_upd   = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        for (int k = DIGITS - 1; k >= 1; k--) begin
            higher_zero = higher_zero && (new_dig[k] == 4'd0);
            blank[k]    = BLANK_LEADING && !ovf_d && higher_zero;
        end

        if (disp_upd) begin
            for (int k = 0; k < DIGITS; k++) begin
                seg_d[k] = blank[k] ? SEG_BLANK : seg7(new_dig[k]);
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            disp_hex_q <= 1'b0;
            shreg_q    <= '0;
            bcd_q      <= '0;
            cnt_q      <= '0;
            seg_q      <= {{(DIGITS-1){RST_HI}}, SEG_ZERO};
            busy_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            disp_hex_q <= disp_hex_d;
            shreg_q    <= shreg_d;
            bcd_q      <= bcd_d;
            cnt_q      <= cnt_d;
            seg_q      <= seg_d;
            busy_q     <= busy_d;
            ovf_q      <= ovf_d;
        end
    end

    assign hex0     = seg_q[0];
    assign hex1     = seg_q[1];
    assign hex2     = seg_q[2];
    assign hex3     = seg_q[3];
    assign hex4     = seg_q[4];
    assign hex5     = seg_q[5];
    assign hex6     = seg_q[6];
    assign hex7     = seg_q[7];
    assign busy     = busy_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_gpio_hex_display.sv
// Self-checking bench for gpio_hex_display: table vectors, multi-cycle corner sequences,
// and random values checked against a plain-arithmetic display model.
module tb_gpio_hex_display;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] gpio_value;
    logic        hex_mode;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic        busy, overflow;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    gpio_hex_display #(.BLANK_LEADING(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .gpio_value(gpio_value), .hex_mode(hex_mode),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7),
        .busy(busy), .overflow(overflow)
    );

    always #5 clk = ~clk;

    logic [55:0] disp;
    assign disp = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    typedef struct {
        logic [31:0] value;
        logic        mode;
        logic [55:0] segs;
        logic        ovf;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: digits from division/nibble extraction, blank above the top significant digit
    task automatic model(input logic [31:0] v, input logic hexm,
                         output logic [55:0] segs, output logic ovf);
        longint unsigned x;
        int dig [8];
        int top;
        x   = longint'(v);
        ovf = 1'b0;
        if (!hexm) ovf = (x > 64'd99999999);
        for (int k = 0; k < 8; k++) begin
            if (hexm) begin
                dig[k] = int'(x % 16);
                x      = x / 16;
            end else begin
                dig[k] = int'(x % 10);
                x      = x / 10;
            end
        end
        top = 0;
        for (int k = 0; k < 8; k++) if (dig[k] != 0) top = k;
        for (int k = 0; k < 8; k++) begin
            if (k > top && !ovf) segs[7*k +: 7] = 7'h7F;
            else                 segs[7*k +: 7] = SEG_TAB[dig[k]];
        end
    endtask

    task automatic wait_not_busy(output int n);
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Drive one value, let it reach the display, and report busy-edge count for decimal
    task automatic apply(input string name, input logic [31:0] v, input logic m);
        int n;
        gpio_value = v;
        hex_mode   = m;
        tick();
        if (m) begin
            chk({name, " busy_hex"}, 64'(busy), 64'd0);
        end else begin
            chk({name, " busy_rise"}, 64'(busy), 64'd1);
            wait_not_busy(n);
            chk({name, " busy_edges"}, 64'(n + 1), 64'd34);
        end
    endtask

    vec_t vecs [12];
    logic [55:0] exp_segs;
    logic        exp_ovf;
    logic [31:0] last_src;
    logic        last_hex;
    logic        saw_busy;
    int          n;

    initial begin
        vecs[0]  = '{32'd1234,      1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h24,7'h30,7'h19}, 1'b0};
        vecs[1]  = '{32'hFFFFFFFF,  1'b0, {7'h10,7'h19,7'h10,7'h02,7'h78,7'h24,7'h10,7'h12}, 1'b1};
        vecs[2]  = '{32'hDEADBEEF,  1'b1, {7'h21,7'h06,7'h08,7'h21,7'h03,7'h06,7'h06,7'h0E}, 1'b0};
        vecs[3]  = '{32'hDEADBEEF,  1'b0, {7'h30,7'h12,7'h10,7'h24,7'h00,7'h12,7'h12,7'h10}, 1'b1};
        vecs[4]  = '{32'h0,         1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 1'b0};
        vecs[5]  = '{32'h0,         1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h40}, 1'b0};
        vecs[6]  = '{32'h10,        1'b1, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h40}, 1'b0};
        vecs[7]  = '{32'd10,        1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h79,7'h40}, 1'b0};
        vecs[8]  = '{32'd100000000, 1'b0, {7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40,7'h40}, 1'b1};
        vecs[9]  = '{32'd99999999,  1'b0, {7'h10,7'h10,7'h10,7'h10,7'h10,7'h10,7'h10,7'h10}, 1'b0};
        vecs[10] = '{32'h00F00000,  1'b1, {7'h7F,7'h7F,7'h0E,7'h40,7'h40,7'h40,7'h40,7'h40}, 1'b0};
        vecs[11] = '{32'd7,         1'b0, {7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h7F,7'h78}, 1'b0};

        // Reset for two edges
        rst_n = 1'b0; gpio_value = '0; hex_mode = 1'b0;
        tick(); tick();
        chk("rst_disp", 64'(disp), 64'({{7{7'h7F}}, 7'h40}));
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ovf",  64'(overflow), 64'd0);
        rst_n = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (busy) saw_busy = 1'b1;
        end
        chk("idle_after_rst_busy", 64'(saw_busy), 64'd0);
        chk("idle_after_rst_disp", 64'(disp), 64'({{7{7'h7F}}, 7'h40}));

        for (int i = 0; i < 12; i++) begin
            apply($sformatf("vec%0d", i), vecs[i].value, vecs[i].mode);
            chk($sformatf("vec%0d_disp", i), 64'(disp), 64'(vecs[i].segs));
            chk($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].ovf));
        end

        // Value change at E5 is ignored until the first conversion finishes
        gpio_value = 32'd5; hex_mode = 1'b0;
        tick();
        chk("chg_busy_e0", 64'(busy), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        gpio_value = 32'd77;
        wait_not_busy(n);
        chk("chg_first_edges", 64'(n), 64'd29);
        model(32'd5, 1'b0, exp_segs, exp_ovf);
        chk("chg_first_disp", 64'(disp), 64'(exp_segs));
        tick();
        chk("chg_second_busy", 64'(busy), 64'd1);
        chk("chg_hold_disp", 64'(disp), 64'(exp_segs));
        wait_not_busy(n);
        chk("chg_second_edges", 64'(n), 64'd33);
        model(32'd77, 1'b0, exp_segs, exp_ovf);
        chk("chg_second_disp", 64'(disp), 64'(exp_segs));

        // Reset at E10 of a conversion, then re-convert the still-present value
        gpio_value = 32'd99999999;
        tick();
        for (int i = 0; i < 9; i++) tick();
        chk("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_disp", 64'(disp), 64'({{7{7'h7F}}, 7'h40}));
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_ovf", 64'(overflow), 64'd0);
        tick();
        chk("mid_restart_busy", 64'(busy), 64'd1);
        wait_not_busy(n);
        chk("mid_restart_edges", 64'(n), 64'd33);
        chk("mid_restart_disp", 64'(disp), 64'({8{7'h10}}));
        chk("mid_restart_ovf", 64'(overflow), 64'd0);

        // Randomized values in both modes against the model
        last_src = 32'd99999999;
        last_hex = 1'b0;
        for (int i = 0; i < 24; i++) begin
            logic [31:0] v;
            logic        m;
            v = $urandom >> $urandom_range(0, 31);
            m = 1'($urandom_range(0, 1));
            if (!m && !last_hex && v == last_src) v = v + 32'd1;
            apply($sformatf("rnd%0d", i), v, m);
            model(v, m, exp_segs, exp_ovf);
            chk($sformatf("rnd%0d_disp v=%h m=%0d", i, v, m), 64'(disp), 64'(exp_segs));
            chk($sformatf("rnd%0d_ovf", i), 64'(overflow), 64'(exp_ovf));
            last_src = v;
            last_hex = m;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_hex_display.md
# gpio_hex_display

Downstream consumer of the core's 32-bit GPIO output register. It converts the latched value into eight active-low seven-segment digit patterns for the board displays. In decimal mode it runs a sequential shift-and-add-3 (double-dabble) binary-to-BCD conversion at one bit per cycle; in hex mode it shows the raw nibbles. It includes leading-zero blanking and overflow indication.

## Interface
- BLANK_LEADING, default 1: when 1, leading zero digits above hex0 are blanked. hex0 is never blanked.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- gpio_value  input  32  value from the core's GPIO output register, treated as unsigned.
- hex_mode  input  1  1 = hexadecimal display, 0 = unsigned decimal display.
- hex0..hex7  output  7 each  segment patterns; hex0 is the least significant digit. Bit order {g,f,e,d,c,b,a}; 0 = segment lit.
- busy  output  1  high while a decimal conversion is in progress (states SHIFT and DONE).
- overflow  output  1  high when the displayed decimal value exceeds 99_999_999, so only the low 8 digits are shown. Always 0 in hex mode.

## Operation
- Segment codes for digits 0-F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex). Blank = 7F.
- Internal registers:
  - src_q[31:0]: last value accepted.
  - disp_hex_q: the current display came from hex mode.
  - shreg[31:0]: binary shift source.
  - bcd[39:0]: ten BCD digits.
  - cnt[5:0]: iteration counter.
  - Eight 4-bit display digit registers and a blank mask.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, hex_mode=1:
  - Every cycle, src_q <= gpio_value, digit k <= gpio_value[4k+3:4k], disp_hex_q <= 1, overflow <= 0.
  - Blanking in hex mode applies to leading zero nibbles.
- IDLE, hex_mode=0, starting a conversion:
  - Trigger: gpio_value != src_q, or disp_hex_q == 1.
  - On the trigger: src_q <= gpio_value, shreg <= gpio_value, bcd <= 0, cnt <= 0, go to SHIFT.
- SHIFT, each cycle:
  - Every BCD digit >= 5 gets +3 first.
  - Then {bcd,shreg} shifts left by 1, and cnt increments.
  - After the 32nd shift (cnt reaches 31 on entry), go to DONE.
- DONE, one cycle:
  - If hex_mode == 0: the low 8 BCD digits load into the display registers, overflow <= (bcd[39:32] != 0), disp_hex_q <= 0.
  - If hex_mode became 1 during the conversion, the result is discarded.
  - Return to IDLE.
- Blanking (BLANK_LEADING=1, overflow=0): digit k (k>=1) is blanked when it and all higher digits are zero. With overflow=1, all eight digits are shown.
- While in SHIFT or DONE, gpio_value changes are ignored. On return to IDLE the current gpio_value is compared against src_q, so only the latest value is converted and intermediate values are dropped.
- hex0..hex7 are registered and change only on a display-register update. They hold their value during a conversion.

## Timing
- Reset (rst_n=0 at an edge), including mid-conversion:
  - State IDLE; src_q=0, disp_hex_q=0, cnt=0, bcd=0.
  - Display shows decimal 0: hex0=40, hex1..hex7=7F (all 40 if BLANK_LEADING=0).
  - busy=0, overflow=0.
  - No conversion is pending after reset with gpio_value=0.
- Decimal latency: gpio_value changes before edge E0 (IDLE). E0 loads; E1..E32 shift; E33 (DONE) updates the hex outputs and overflow. Outputs are valid after E33. busy is high from after E0 through E33 inclusive, and low after E33.
- Back-to-back conversions: the earliest restart is the edge after E33 (a new E0). Minimum period is 34 cycles.
- Hex latency: 1 edge from gpio_value to the hex outputs while in IDLE.
- Arithmetic: the add-3 compare is per 4-bit digit and combinational inside SHIFT. Nothing wraps, because the 40-bit BCD holds the 32-bit maximum, 4_294_967_295.

## Test plan
- **Reset:** assert rst_n=0 for 2 cycles with gpio_value=0 -> hex0=40, hex1..7=7F, busy=0, overflow=0. Hold 50 cycles: busy stays 0.
- **Decimal 1234:** gpio_value=1234, hex_mode=0 -> busy high for exactly 34 edges; then hex3..hex0 = 79,24,30,19, hex4..7=7F, overflow=0.
- **Overflow:** gpio_value=FFFFFFFF -> after 34 edges, hex7..hex0 = 10,19,10,02,78,24,10,12 (94967295) and overflow=1.
- **Hex mode:** hex_mode=1, gpio_value=DEADBEEF -> next edge hex7..hex0 = 21,06,08,21,03,06,06,0E. Switch to hex_mode=0 -> conversion starts and shows 3735928559 low digits 35928559 with overflow=1.
- **Change during conversion:** 5 then 77 set at E5 -> the display shows 5 after E33. A second conversion then runs, and the display shows 77 after 34 more edges.
- **Reset mid-conversion:** rst_n=0 at E10 of converting 99999999 -> the outputs return to the reset values. On release, gpio_value is still 99999999, so it converts and all digits show 10 after 34 edges.
